spi_flash_reader: RTL and testbench

Sequencer that drives the SPI byte engine (`spi`) to perform a standard serial-flash READ (opcode, 24-bit address, N data bytes) without CPU involvement. It owns slave select and the engine's byte-stream ports, discards header echo bytes, and presents data bytes on a valid/ready stream. It is used for boot/ROM fetch alongside, or instead of, the Wishbone SPI FIFO front end.

---
 rtl/spi_flash_reader.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// Runs a serial-flash READ (opcode, 24-bit address, N data bytes) through a
// byte-at-a-time SPI engine without CPU help. The block owns slave select.
// It drops the echo bytes clocked in during the header.
// Data bytes are handed downstream on a valid/ready stream.
// Exactly one byte is ever in flight in the engine. When a transfer is cut
// short, any byte the engine has already taken is still drained, so the
// engine is never left holding a byte that nobody will read.
module spi_flash_reader #(
  parameter int         LEN_W  = 16,
  parameter logic [7:0] CMD    = 8'h03,
  parameter logic [7:0] DUMMY  = 8'hFF,
  parameter int         CS_GAP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       spi_din,
  output logic             spi_din_valid,
  input  logic             spi_din_ready,
  input  logic [7:0]       spi_dout,
  input  logic             spi_dout_valid,
  output logic             spi_dout_ready,
  output logic             ss,
  output logic [7:0]       dat_o,
  output logic             dat_valid,
  input  logic             dat_ready
);

  // Gap counter runs 0..CS_GAP-1.
  localparam int               CNT_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [2:0]       HDR_LEN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_TX    = 3'd2,
    ST_RX    = 3'd3,
    ST_OUT   = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Byte to shift out for a given header index; past the header it is DUMMY.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [23:0] a);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD;
      3'd1:    b = a[23:16];
      3'd2:    b = a[15:8];
      3'd3:    b = a[7:0];
      default: b = DUMMY;
    endcase
    return b;
  endfunction

  // Current state / registers
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       hdr_idx_r;
  logic [23:0]      addr_r;
  logic [LEN_W-1:0] rem_r;
  logic             abort_pend_r;
  logic             ss_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       spi_din_r;
  logic             spi_din_valid_r;
  logic             spi_dout_ready_r;
  logic [7:0]       dat_o_r;
  logic             dat_valid_r;

  // Next-state values
  state_t           state_s;
  logic [CNT_W-1:0] cnt_s;
  logic [2:0]       hdr_idx_s;
  logic [23:0]      addr_s;
  logic [LEN_W-1:0] rem_s;
  logic             abort_pend_s;
  logic             ss_s;
  logic             busy_s;
  logic             done_s;
  logic [7:0]       spi_din_s;
  logic             spi_din_valid_s;
  logic             spi_dout_ready_s;
  logic [7:0]       dat_o_s;
  logic             dat_valid_s;

  // State and output registers; reset drops everything back to an idle bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= ST_IDLE;
      cnt_r            <= CNT_ZERO;
      hdr_idx_r        <= 3'd0;
      addr_r           <= 24'd0;
      rem_r            <= LEN_ZERO;
      abort_pend_r     <= 1'b0;
      ss_r             <= 1'b1;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      spi_din_r        <= 8'd0;
      spi_din_valid_r  <= 1'b0;
      spi_dout_ready_r <= 1'b0;
      dat_o_r          <= 8'd0;
      dat_valid_r      <= 1'b0;
    end else begin
      state_r          <= state_s;
      cnt_r            <= cnt_s;
      hdr_idx_r        <= hdr_idx_s;
      addr_r           <= addr_s;
      rem_r            <= rem_s;
      abort_pend_r     <= abort_pend_s;
      ss_r             <= ss_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
      spi_din_r        <= spi_din_s;
      spi_din_valid_r  <= spi_din_valid_s;
      spi_dout_ready_r <= spi_dout_ready_s;
      dat_o_r          <= dat_o_s;
      dat_valid_r      <= dat_valid_s;
    end
  end

  // Sequencer: next state and next value of every registered output.
  always_comb begin
    state_s          = state_r;
    cnt_s            = cnt_r;
    hdr_idx_s        = hdr_idx_r;
    addr_s           = addr_r;
    rem_s            = rem_r;
    abort_pend_s     = abort_pend_r;
    ss_s             = ss_r;
    busy_s           = busy_r;
    done_s           = 1'b0;
    spi_din_s        = spi_din_r;
    spi_din_valid_s  = spi_din_valid_r;
    spi_dout_ready_s = spi_dout_ready_r;
    dat_o_s          = dat_o_r;
    dat_valid_s      = dat_valid_r;

    case (state_r)
      ST_IDLE: begin
        // abort has no meaning here; start wins when both are high
        if (start) begin
          if (len != LEN_ZERO) begin
            addr_s       = addr;
            rem_s        = len;
            hdr_idx_s    = 3'd0;
            cnt_s        = CNT_ZERO;
            abort_pend_s = 1'b0;
            ss_s         = 1'b0;
            busy_s       = 1'b1;
            state_s      = ST_SETUP;
          end else begin
            // zero-length read: report completion without touching the bus
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (abort) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_HOLD;
        end else if (cnt_r == GAP_LAST) begin
          spi_din_s       = tx_byte(hdr_idx_r, addr_r);
          spi_din_valid_s = 1'b1;
          state_s         = ST_TX;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_TX: begin
        if (spi_din_valid_r && spi_din_ready) begin
          // byte is now in the engine: its echo must be drained even if
          // abort arrives in this very cycle
          spi_din_valid_s  = 1'b0;
          spi_dout_ready_s = 1'b1;
          abort_pend_s     = abort;
          state_s          = ST_RX;
        end else if (abort) begin
          spi_din_valid_s = 1'b0;
          cnt_s           = CNT_ZERO;
          state_s         = ST_HOLD;
        end else begin
          state_s = ST_TX;
        end
      end

      ST_RX: begin
        if (spi_dout_valid) begin
          spi_dout_ready_s = 1'b0;
          if (abort || abort_pend_r) begin
            abort_pend_s = 1'b0;
            cnt_s        = CNT_ZERO;
            state_s      = ST_HOLD;
          end else if (hdr_idx_r < HDR_LEN) begin
            // header echo: discard and send the next header/dummy byte
            hdr_idx_s       = hdr_idx_r + 3'd1;
            spi_din_s       = tx_byte(hdr_idx_r + 3'd1, addr_r);
            spi_din_valid_s = 1'b1;
            state_s         = ST_TX;
          end else begin
            dat_o_s     = spi_dout;
            dat_valid_s = 1'b1;
            state_s     = ST_OUT;
          end
        end else if (abort) begin
          abort_pend_s = 1'b1;
        end else begin
          state_s = ST_RX;
        end
      end

      ST_OUT: begin
        if (abort) begin
          dat_valid_s = 1'b0;
          cnt_s       = CNT_ZERO;
          state_s     = ST_HOLD;
        end else if (dat_ready) begin
          dat_valid_s = 1'b0;
          rem_s       = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_HOLD;
          end else begin
            spi_din_s       = DUMMY;
            spi_din_valid_s = 1'b1;
            state_s         = ST_TX;
          end
        end else begin
          // downstream stall: nothing new goes to the engine
          state_s = ST_OUT;
        end
      end

      ST_HOLD: begin
        // abort is irrelevant here; the gap always runs to completion
        if (cnt_r == GAP_LAST) begin
          ss_s    = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        ss_s             = 1'b1;
        busy_s           = 1'b0;
        spi_din_valid_s  = 1'b0;
        spi_dout_ready_s = 1'b0;
        dat_valid_s      = 1'b0;
        state_s          = ST_IDLE;
      end
    endcase
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign spi_din        = spi_din_r;
  assign spi_din_valid  = spi_din_valid_r;
  assign spi_dout_ready = spi_dout_ready_r;
  assign ss             = ss_r;
  assign dat_o          = dat_o_r;
  assign dat_valid      = dat_valid_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: directed scenarios plus randomized reads,
// checked against a transaction-level model of the flash READ protocol.
module tb_spi_flash_reader;

  localparam int         CS_GAP = 4;
  localparam logic [7:0] CMD_C  = 8'h03;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] addr;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [7:0]  spi_din;
  logic        spi_din_valid;
  logic        spi_din_ready;
  logic [7:0]  spi_dout;
  logic        spi_dout_valid;
  logic        spi_dout_ready;
  logic        ss;
  logic [7:0]  dat_o;
  logic        dat_valid;
  logic        dat_ready;

  spi_flash_reader #(
    .LEN_W(16), .CMD(CMD_C), .DUMMY(8'hFF), .CS_GAP(CS_GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start(start), .addr(addr), .len(len),
    .abort(abort), .busy(busy), .done(done),
    .spi_din(spi_din), .spi_din_valid(spi_din_valid), .spi_din_ready(spi_din_ready),
    .spi_dout(spi_dout), .spi_dout_valid(spi_dout_valid), .spi_dout_ready(spi_dout_ready),
    .ss(ss), .dat_o(dat_o), .dat_valid(dat_valid), .dat_ready(dat_ready)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;

  // observation of the current transaction
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] dat_q[$];
  logic [7:0] rx_script[$];
  int done_cnt, done_cyc, ss_fall, ss_rise, first_valid, last_hs, last_dout_hs, bad;
  bit busy_seen;
  logic prev_ss = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // SPI engine model: takes a byte, returns one the following cycle
  initial begin : engine
    bit take_q;
    bit hs_q;
    logic [7:0] b;
    take_q = 1'b0;
    hs_q = 1'b0;
    spi_dout_valid = 1'b0;
    spi_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        take_q = 1'b0;
        hs_q = 1'b0;
        spi_dout_valid = 1'b0;
      end else begin
        if (hs_q) spi_dout_valid = 1'b0;
        if (take_q) begin
          if (rx_script.size() > 0) b = rx_script.pop_front();
          else b = 8'($urandom);
          spi_dout = b;
          spi_dout_valid = 1'b1;
          rx_q.push_back(b);
        end
        if (rand_mode) begin
          spi_din_ready = 1'($urandom_range(0, 1));
          dat_ready = ($urandom_range(0, 3) != 0);
        end
        take_q = spi_din_valid && spi_din_ready;
        if (take_q) tx_q.push_back(spi_din);
        hs_q = spi_dout_valid && spi_dout_ready;
      end
    end
  end

  // Monitor: records events of the running transaction
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (!ss && ss_fall < 0) ss_fall = cyc;
        if (ss && !prev_ss && ss_rise < 0) ss_rise = cyc;
        if (spi_din_valid && first_valid < 0) first_valid = cyc;
        if (dat_valid && dat_ready) begin
          dat_q.push_back(dat_o);
          last_hs = cyc;
        end
        if (spi_dout_valid && spi_dout_ready) last_dout_hs = cyc;
        if (done) begin
          done_cnt = done_cnt + 1;
          done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
        if (busy == ss) bad = bad + 1;
        if (spi_din_valid && ss) bad = bad + 1;
      end else if (done) begin
        done_cnt = done_cnt + 1;
      end
      prev_ss = ss;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    tx_q.delete();
    rx_q.delete();
    dat_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    ss_fall = -1;
    ss_rise = -1;
    first_valid = -1;
    last_hs = -1;
    last_dout_hs = -1;
    bad = 0;
    busy_seen = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l, output int s);
    clear_obs();
    addr = a;
    len = l;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    addr = 24'($urandom);
    len = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n = n + 1;
    end
    chk({tag, ".no_timeout"}, 32'(n < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Transaction-level reference: header is opcode + big-endian address,
  // every byte after it is a dummy; data bytes are the engine's echoes
  // after the first four.
  task automatic check_txn(input string tag, input logic [23:0] a, input int ntx,
                           input int ndata, input int s, input bit aborted);
    logic [7:0] exp_tx[$];
    int end_ref;
    exp_tx = {CMD_C, a[23:16], a[15:8], a[7:0]};
    while (exp_tx.size() < ntx) exp_tx.push_back(8'hFF);
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ".tx_len"}, 32'(tx_q.size()), 32'(ntx));
    for (int i = 0; i < ntx && i < tx_q.size(); i++)
      chk($sformatf("%s.tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
    chk({tag, ".rx_len"}, 32'(rx_q.size()), 32'(ntx));
    chk({tag, ".dat_len"}, 32'(dat_q.size()), 32'(ndata));
    for (int i = 0; i < ndata && i < dat_q.size() && 4 + i < rx_q.size(); i++)
      chk($sformatf("%s.dat%0d", tag, i), 32'(dat_q[i]), 32'(rx_q[4 + i]));
    chk({tag, ".ss_fall"}, 32'(ss_fall), 32'(s + 1));
    chk({tag, ".first_valid"}, 32'(first_valid), 32'(s + 1 + CS_GAP));
    end_ref = aborted ? last_dout_hs : last_hs;
    chk({tag, ".done_cyc"}, 32'(done_cyc), 32'(end_ref + 1 + CS_GAP));
    chk({tag, ".ss_rise"}, 32'(ss_rise), 32'(done_cyc));
    chk({tag, ".protocol"}, 32'(bad), 32'd0);
    chk({tag, ".dout_left"}, 32'(spi_dout_valid), 32'd0);
  endtask

  initial begin : main
    int s;
    int stall_bad;
    int n;
    logic [23:0] a;
    logic [15:0] l;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    addr = 24'd0;
    len = 16'd0;
    spi_din_ready = 1'b1;
    dat_ready = 1'b1;
    clear_obs();

    // reset values
    repeat (3) @(negedge clk);
    chk("reset.ctrl", 32'({ss, busy, done, spi_din_valid, spi_dout_ready, dat_valid}), 32'b100000);
    chk("reset.spi_din", 32'(spi_din), 32'd0);
    chk("reset.dat_o", 32'(dat_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic read
    rx_script = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5A, 8'hC3};
    do_start(24'h123456, 16'd2, s);
    wait_done("basic");
    check_txn("basic", 24'h123456, 6, 2, s, 1'b0);
    if (dat_q.size() == 2) begin
      chk("basic.byte0", 32'(dat_q[0]), 32'h5A);
      chk("basic.byte1", 32'(dat_q[1]), 32'hC3);
    end else begin
      chk("basic.bytes_present", 32'(dat_q.size()), 32'd2);
    end

    // backpressure on the first data byte
    rx_script = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5A, 8'hC3};
    dat_ready = 1'b0;
    do_start(24'h123456, 16'd2, s);
    n = 0;
    while (!dat_valid && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("bp.dat_valid_seen", 32'(dat_valid), 32'd1);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!dat_valid || dat_o !== 8'h5A || spi_din_valid) stall_bad = stall_bad + 1;
    end
    chk("bp.stall_stable", 32'(stall_bad), 32'd0);
    dat_ready = 1'b1;
    wait_done("bp");
    check_txn("bp", 24'h123456, 6, 2, s, 1'b0);

    // zero-length request
    do_start(24'hABCDEF, 16'd0, s);
    repeat (8) @(negedge clk);
    chk("len0.done_cnt", 32'(done_cnt), 32'd1);
    chk("len0.done_cyc", 32'(done_cyc), 32'(s + 1));
    chk("len0.ss_never_low", 32'(ss_fall), 32'hFFFF_FFFF);
    chk("len0.no_tx", 32'(first_valid), 32'hFFFF_FFFF);
    chk("len0.busy_never", 32'(busy_seen), 32'd0);

    // abort while the second data byte is in flight
    a = 24'($urandom);
    do_start(a, 16'd4, s);
    n = 0;
    while (dat_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    while (!spi_dout_ready && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    check_txn("abort", a, 6, 1, s, 1'b1);

    // start while busy is ignored
    a = 24'($urandom);
    do_start(a, 16'd3, s);
    repeat (CS_GAP + 6) @(negedge clk);
    addr = ~a;
    len = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    repeat (10) @(negedge clk);
    check_txn("busy_start", a, 7, 3, s, 1'b0);
    chk("busy_start.idle_after", 32'({busy, ss}), 32'b01);

    // asynchronous reset in the middle of the header
    a = 24'($urandom);
    do_start(a, 16'd2, s);
    n = 0;
    while (!(spi_din_valid && cyc > s + 1 + CS_GAP + 2) && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("rst_tx.in_tx", 32'(spi_din_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_tx.ctrl", 32'({ss, busy, done, spi_din_valid, spi_dout_ready, dat_valid}), 32'b100000);
    chk("rst_tx.spi_din", 32'(spi_din), 32'd0);
    chk("rst_tx.dat_o", 32'(dat_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tx.no_done", 32'(done_cnt), 32'd0);
    a = 24'($urandom);
    do_start(a, 16'd3, s);
    wait_done("after_rst");
    check_txn("after_rst", a, 7, 3, s, 1'b0);

    // randomized reads with random engine and downstream readiness
    rand_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 24'($urandom);
      l = 16'($urandom_range(1, 6));
      do_start(a, l, s);
      wait_done($sformatf("rand%0d", k));
      check_txn($sformatf("rand%0d", k), a, 4 + int'(l), int'(l), s, 1'b0);
    end
    rand_mode = 1'b0;
    spi_din_ready = 1'b1;
    dat_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
